test_end_monitor: RTL and testbench

- Synthesizable successor to the simulation-only tohost watcher.
- Watches the IFU PC stream against NUM_WATCH programmable end-of-test addresses and counts distinct arrivals.
- Once the hit count reaches HIT_THRESH, samples the result GPR (x3) and latches a pass/fail verdict with cycle statistics.
- Sits beside alioth_cpu_top in the SoC so FPGA builds and Verilator runs share one end-of-test mechanism.

---
 rtl/test_end_monitor.sv | 157 +++++++++++++++
 tb/tb_test_end_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/test_end_monitor.sv
// End-of-test monitor: counts distinct PC arrivals at programmable watch addresses,
// then latches a pass/fail verdict from x3. Define TEST_MON_TIMEOUT_EN to enable the RUN timeout.
module test_end_monitor #(
  parameter int ADDR_W       = 32,
  parameter int NUM_WATCH    = 2,
  parameter int HIT_THRESH   = 8,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT_LOG2 = 20,
  parameter int PASS_VAL     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [ADDR_W-1:0]           pc_i,
  input  logic                        pc_valid_i,
  input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr_i,
  input  logic [NUM_WATCH-1:0]        watch_en_i,
  input  logic [31:0]                 result_i,
  output logic                        done_o,
  output logic                        pass_o,
  output logic                        fail_o,
  output logic                        timeout_o,
  output logic [7:0]                  hit_cnt_o,
  output logic [2:0]                  hit_idx_o,
  output logic [CNT_W-1:0]            cycle_cnt_o,
  output logic [CNT_W-1:0]            end_cycle_o,
  output logic [31:0]                 fail_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [7:0]  THRESH = 8'(HIT_THRESH);
  localparam logic [31:0] PASS_V = 32'(PASS_VAL);

  if (TIMEOUT_LOG2 >= CNT_W) begin : g_bad_timeout_cfg
    $error("TIMEOUT_LOG2 must be below CNT_W");
  end

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  last_pc_q;
  logic               last_valid_q;
  logic [7:0]         hit_cnt_q, hit_cnt_d;
  logic [2:0]         hit_idx_q, hit_idx_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   end_cycle_q, end_cycle_d;
  logic [31:0]        fail_code_q, fail_code_d;

  logic       match;
  logic [2:0] match_idx;
  logic       hit;
  logic       final_hit;
  logic       timeout_fire;

  // Descending scan so the lowest matching channel is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int k = NUM_WATCH - 1; k >= 0; k--) begin
      if (pc_valid_i && watch_en_i[k] && (pc_i == watch_addr_i[k*ADDR_W +: ADDR_W])) begin
        match     = 1'b1;
        match_idx = 3'(k);
      end
    end
  end

  // A PC held across stalls must not be counted again.
  assign hit       = (state_q == S_RUN) && match && (!last_valid_q || (pc_i != last_pc_q));
  assign final_hit = hit && ((hit_cnt_q + 8'd1) == THRESH);

`ifdef TEST_MON_TIMEOUT_EN
  assign timeout_fire = (state_q == S_RUN) && cycle_cnt_q[TIMEOUT_LOG2];
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hit_cnt_d   = hit_cnt_q;
    hit_idx_d   = hit_idx_q;
    cycle_cnt_d = cycle_cnt_q;
    end_cycle_d = end_cycle_q;
    fail_code_d = fail_code_q;

    case (state_q)
      S_IDLE: begin
        hit_cnt_d   = '0;
        hit_idx_d   = '0;
        cycle_cnt_d = '0;
        end_cycle_d = '0;
        fail_code_d = '0;
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (hit) begin
          hit_idx_d = match_idx;
          if (hit_cnt_q == 8'd0) end_cycle_d = cycle_cnt_q;
          if (hit_cnt_q != THRESH) hit_cnt_d = hit_cnt_q + 8'd1;
        end
        if (final_hit) begin
          fail_code_d = result_i;
          state_d     = (result_i == PASS_V) ? S_PASS : S_FAIL;
        end else if (timeout_fire) begin
          state_d = S_TIMEOUT;
        end
      end
      default: ;
    endcase

    if (clear_i) begin
      state_d     = S_IDLE;
      hit_cnt_d   = '0;
      hit_idx_d   = '0;
      cycle_cnt_d = '0;
      end_cycle_d = '0;
      fail_code_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
      hit_cnt_q    <= '0;
      hit_idx_q    <= '0;
      cycle_cnt_q  <= '0;
      end_cycle_q  <= '0;
      fail_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_pc_q    <= pc_i;
      last_valid_q <= pc_valid_i;
      hit_cnt_q    <= hit_cnt_d;
      hit_idx_q    <= hit_idx_d;
      cycle_cnt_q  <= cycle_cnt_d;
      end_cycle_q  <= end_cycle_d;
      fail_code_q  <= fail_code_d;
    end
  end

  assign done_o      = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
  assign pass_o      = (state_q == S_PASS);
  assign fail_o      = (state_q == S_FAIL);
`ifdef TEST_MON_TIMEOUT_EN
  assign timeout_o   = (state_q == S_TIMEOUT);
`else
  assign timeout_o   = 1'b0;
`endif
  assign hit_cnt_o   = hit_cnt_q;
  assign hit_idx_o   = hit_idx_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign end_cycle_o = end_cycle_q;
  assign fail_code_o = fail_code_q;

endmodule

// File: tb/tb_test_end_monitor.sv
// Scoreboard bench for test_end_monitor: stimulus queues expected snapshots/verdicts,
// a negedge monitor pops and compares them.
module tb_test_end_monitor;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        clear_i;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic [63:0] watch_addr_i;
  logic [1:0]  watch_en_i;
  logic [31:0] result_i;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [7:0]  hit_cnt_o;
  logic [2:0]  hit_idx_o;
  logic [31:0] cycle_cnt_o, end_cycle_o, fail_code_o;

  test_end_monitor #(
    .ADDR_W(32), .NUM_WATCH(2), .HIT_THRESH(8), .CNT_W(32), .TIMEOUT_LOG2(4), .PASS_VAL(1)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .watch_addr_i(watch_addr_i),
    .watch_en_i(watch_en_i), .result_i(result_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .hit_cnt_o(hit_cnt_o), .hit_idx_o(hit_idx_o), .cycle_cnt_o(cycle_cnt_o),
    .end_cycle_o(end_cycle_o), .fail_code_o(fail_code_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    bit          is_verdict;
    int          at_cyc;
    logic        done, pass, fail, tmo;
    logic [7:0]  hc;
    logic [2:0]  hi;
    logic [31:0] cc, ec, fc;
  } exp_t;

  exp_t exp_q[$];
  int   snap_pend = 0;
  int   checks = 0;
  int   errors = 0;
  int   tb_cyc = 0;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  function automatic void chk(string n, string f, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got=%0h want=%0h", n, f, got, want);
    end
  endfunction

  task automatic pop_check(bit verdict);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s got=output want=none", verdict ? "verdict" : "snapshot");
      return;
    end
    e = exp_q.pop_front();
    chk(e.name, "kind", 32'(verdict), 32'(e.is_verdict));
    if (verdict) chk(e.name, "latency_cycle", tb_cyc, e.at_cyc);
    chk(e.name, "done",      32'(done_o),    32'(e.done));
    chk(e.name, "pass",      32'(pass_o),    32'(e.pass));
    chk(e.name, "fail",      32'(fail_o),    32'(e.fail));
    chk(e.name, "timeout",   32'(timeout_o), 32'(e.tmo));
    chk(e.name, "hit_cnt",   32'(hit_cnt_o), 32'(e.hc));
    chk(e.name, "hit_idx",   32'(hit_idx_o), 32'(e.hi));
    chk(e.name, "cycle_cnt", cycle_cnt_o,    e.cc);
    chk(e.name, "end_cycle", end_cycle_o,    e.ec);
    chk(e.name, "fail_code", fail_code_o,    e.fc);
  endtask

  // Monitor: snapshots first, then a rising done_o consumes a verdict entry.
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      while (snap_pend > 0) begin
        snap_pend--;
        pop_check(1'b0);
      end
      if (done_o && !prev_done) pop_check(1'b1);
      prev_done = done_o;
    end
  end

  task automatic push_exp(string n, bit v, logic d, logic p, logic f, logic t,
                          int hc, int hi, int cc, int ec, int fc);
    exp_t e;
    e.name = n; e.is_verdict = v; e.at_cyc = tb_cyc + 1;
    e.done = d; e.pass = p; e.fail = f; e.tmo = t;
    e.hc = 8'(hc); e.hi = 3'(hi); e.cc = 32'(cc); e.ec = 32'(ec); e.fc = 32'(fc);
    exp_q.push_back(e);
  endtask

  task automatic snap(string n, logic d, logic p, logic f, logic t,
                      int hc, int hi, int cc, int ec, int fc);
    push_exp(n, 1'b0, d, p, f, t, hc, hi, cc, ec, fc);
    snap_pend++;
  endtask

  task automatic drive(input logic [31:0] pc, input logic v);
    pc_i = pc;
    pc_valid_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic c);
    start_i = s;
    clear_i = c;
    pc_valid_i = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    clear_i = 1'b0;
  endtask

  // Eight arrivals at 0xa0, each preceded by 0x40; first hit lands at cycle_cnt 1.
  task automatic eight_hits(string n, logic is_pass, int code);
    for (int i = 0; i < 8; i++) begin
      drive(32'h40, 1'b1);
      if (i == 7) push_exp(n, 1'b1, 1'b1, is_pass, !is_pass, 1'b0, 8, 0, 16, 1, code);
      drive(32'ha0, 1'b1);
      if (i == 2) snap({n, "_mid"}, 0, 0, 0, 0, 3, 0, 6, 1, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; clear_i = 1'b0; pc_i = '0; pc_valid_i = 1'b0;
    watch_addr_i = {32'h0, 32'ha0}; watch_en_i = 2'b01; result_i = 32'd1;
    @(posedge clk); #1;
    snap("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic pass, frozen outputs, clear, restart, clear-beats-start
    pulse(1'b1, 1'b0);
    snap("start", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eight_hits("pass", 1'b1, 1);
    drive(32'h40, 1'b1);
    drive(32'ha0, 1'b1);
    snap("frozen", 1, 1, 0, 0, 8, 0, 16, 1, 1);
    pulse(1'b0, 1'b1);
    snap("clear_pass", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse(1'b1, 1'b0);
    snap("restart", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(32'h40, 1'b1);
    drive(32'h44, 1'b1);
    snap("restart_run", 0, 0, 0, 0, 0, 0, 2, 0, 0);
    pulse(1'b1, 1'b1);
    drive(32'h40, 1'b1);
    snap("clear_wins", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // fail path
    result_i = 32'd5;
    pulse(1'b1, 1'b0);
    eight_hits("fail", 1'b0, 5);
    pulse(1'b0, 1'b1);
    result_i = 32'd1;

    // stall dedupe
    pulse(1'b1, 1'b0);
    repeat (10) drive(32'ha0, 1'b1);
    snap("stall_hold", 0, 0, 0, 0, 1, 0, 10, 0, 0);
    drive(32'ha0, 1'b0);
    snap("stall_invalid", 0, 0, 0, 0, 1, 0, 11, 0, 0);
    drive(32'ha0, 1'b1);
    snap("stall_revalid", 0, 0, 0, 0, 2, 0, 12, 0, 0);
    pulse(1'b0, 1'b1);

    // multi-channel priority
    watch_addr_i = {32'h100, 32'h100};
    watch_en_i = 2'b11;
    pulse(1'b1, 1'b0);
    drive(32'h100, 1'b1);
    snap("prio_both", 0, 0, 0, 0, 1, 0, 1, 0, 0);
    drive(32'h44, 1'b1);
    watch_en_i = 2'b10;
    drive(32'h100, 1'b1);
    snap("prio_ch1", 0, 0, 0, 0, 2, 1, 3, 0, 0);
    watch_en_i = 2'b00;
    drive(32'h44, 1'b1);
    drive(32'h100, 1'b1);
    snap("prio_none", 0, 0, 0, 0, 2, 1, 5, 0, 0);
    pulse(1'b0, 1'b1);
    watch_addr_i = {32'h0, 32'ha0};
    watch_en_i = 2'b01;

    // timeout (cycle_cnt bit 4), then final hit on the timeout cycle
    pulse(1'b1, 1'b0);
`ifdef TEST_MON_TIMEOUT_EN
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) push_exp("timeout", 1'b1, 1, 0, 0, 1, 0, 0, 17, 0, 0);
      drive(32'h40, 1'b1);
    end
`else
    repeat (20) drive(32'h40, 1'b1);
    snap("no_timeout", 0, 0, 0, 0, 0, 0, 20, 0, 0);
`endif
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) push_exp("hit_beats_timeout", 1'b1, 1, 1, 0, 0, 8, 0, 17, 2, 1);
      drive(((i % 2 == 1) && (i >= 3)) ? 32'ha0 : 32'h40, 1'b1);
    end
    pulse(1'b0, 1'b1);

    // async reset mid-run
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(32'h40, 1'b1);
      drive(32'ha0, 1'b1);
    end
    snap("pre_reset", 0, 0, 0, 0, 3, 0, 6, 1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    snap("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(32'h40, 1'b1);
    snap("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) drive(32'h0, 1'b0);
    checks++;
    if (exp_q.size() != 0 || snap_pend != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
